// File: rtl/ysyx_24100006_axi_pkg.sv
// Shared definitions for the AXI N:1 crossbar arbiter: FSM encoding, arbitration
// mode constants and an index-width helper.
package ysyx_24100006_axi_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam int ARB_MODE_RR    = 0;
    localparam int ARB_MODE_FIXED = 1;

    // A single master still needs a one-bit index so the grant registers exist.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ysyx_24100006_rr_picker.sv
// Combinational grant selection: round-robin starting after last_grant, or
// fixed priority where the lowest asserted index wins.
module ysyx_24100006_rr_picker
    import ysyx_24100006_axi_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    input  logic             fixed_mode,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < N; k++) begin
            if (fixed_mode) begin
                cand = k;
            end else begin
                // (last_grant + 1 + k) mod N without a divider
                cand = int'(last_grant) + 1 + k;
                if (cand >= N) cand = cand - N;
                if (cand >= N) cand = cand - N;
            end
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/ysyx_24100006_axi_nxbar_arbiter.sv
// N-master to 1-slave AXI arbiter with independent read and write grants; the
// granted master is forwarded combinationally, others see an idle channel.
module ysyx_24100006_axi_nxbar_arbiter
    import ysyx_24100006_axi_pkg::*;
#(
    parameter int N_MST    = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ARB_MODE = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_MST-1:0]           m_arvalid,
    output logic [N_MST-1:0]           m_arready,
    input  logic [N_MST*ADDR_W-1:0]    m_araddr,
    input  logic [N_MST*8-1:0]         m_arlen,
    input  logic [N_MST*3-1:0]         m_arsize,
    output logic [N_MST-1:0]           m_rvalid,
    input  logic [N_MST-1:0]           m_rready,
    output logic [N_MST*DATA_W-1:0]    m_rdata,
    output logic [N_MST*2-1:0]         m_rresp,
    output logic [N_MST-1:0]           m_rlast,
    input  logic [N_MST-1:0]           m_awvalid,
    output logic [N_MST-1:0]           m_awready,
    input  logic [N_MST*ADDR_W-1:0]    m_awaddr,
    input  logic [N_MST*8-1:0]         m_awlen,
    input  logic [N_MST*3-1:0]         m_awsize,
    input  logic [N_MST-1:0]           m_wvalid,
    output logic [N_MST-1:0]           m_wready,
    input  logic [N_MST*DATA_W-1:0]    m_wdata,
    input  logic [N_MST*DATA_W/8-1:0]  m_wstrb,
    input  logic [N_MST-1:0]           m_wlast,
    output logic [N_MST-1:0]           m_bvalid,
    input  logic [N_MST-1:0]           m_bready,
    output logic [N_MST*2-1:0]         m_bresp,
    output logic                       s_arvalid,
    input  logic                       s_arready,
    output logic [ADDR_W-1:0]          s_araddr,
    output logic [7:0]                 s_arlen,
    output logic [2:0]                 s_arsize,
    input  logic                       s_rvalid,
    output logic                       s_rready,
    input  logic [DATA_W-1:0]          s_rdata,
    input  logic [1:0]                 s_rresp,
    input  logic                       s_rlast,
    output logic                       s_awvalid,
    input  logic                       s_awready,
    output logic [ADDR_W-1:0]          s_awaddr,
    output logic [7:0]                 s_awlen,
    output logic [2:0]                 s_awsize,
    output logic                       s_wvalid,
    input  logic                       s_wready,
    output logic [DATA_W-1:0]          s_wdata,
    output logic [DATA_W/8-1:0]        s_wstrb,
    output logic                       s_wlast,
    input  logic                       s_bvalid,
    output logic                       s_bready,
    input  logic [1:0]                 s_bresp
);

    localparam int IDX_W  = idx_width(N_MST);
    localparam int STRB_W = DATA_W / 8;

    arb_state_e       rstate_reg, rstate_next, wstate_reg, wstate_next;
    logic [IDX_W-1:0] rgnt_reg, rgnt_next, wgnt_reg, wgnt_next;
    logic [IDX_W-1:0] r_last_grant_reg, r_last_grant_next;
    logic [IDX_W-1:0] w_last_grant_reg, w_last_grant_next;
    logic [N_MST-1:0] r_pick_oh, w_pick_oh;
    logic [IDX_W-1:0] r_pick_idx, w_pick_idx;
    logic [N_MST-1:0] rsel, wsel;
    logic [DATA_W-1:0] hold_reg [N_MST];

    ysyx_24100006_rr_picker #(.N(N_MST), .IDX_W(IDX_W)) u_rpick (
        .req        (m_arvalid),
        .last_grant (r_last_grant_reg),
        .fixed_mode (ARB_MODE == ARB_MODE_FIXED),
        .grant      (r_pick_oh),
        .grant_idx  (r_pick_idx)
    );

    ysyx_24100006_rr_picker #(.N(N_MST), .IDX_W(IDX_W)) u_wpick (
        .req        (m_awvalid),
        .last_grant (w_last_grant_reg),
        .fixed_mode (ARB_MODE == ARB_MODE_FIXED),
        .grant      (w_pick_oh),
        .grant_idx  (w_pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rstate_reg       <= ARB_IDLE;
            wstate_reg       <= ARB_IDLE;
            rgnt_reg         <= '0;
            wgnt_reg         <= '0;
            r_last_grant_reg <= IDX_W'(N_MST - 1);
            w_last_grant_reg <= IDX_W'(N_MST - 1);
        end else begin
            rstate_reg       <= rstate_next;
            wstate_reg       <= wstate_next;
            rgnt_reg         <= rgnt_next;
            wgnt_reg         <= wgnt_next;
            r_last_grant_reg <= r_last_grant_next;
            w_last_grant_reg <= w_last_grant_next;
        end
    end

    always_comb begin
        rstate_next       = rstate_reg;
        rgnt_next         = rgnt_reg;
        r_last_grant_next = r_last_grant_reg;
        wstate_next       = wstate_reg;
        wgnt_next         = wgnt_reg;
        w_last_grant_next = w_last_grant_reg;
        case (rstate_reg)
            ARB_IDLE: if (|r_pick_oh) begin
                rstate_next = ARB_BUSY;
                rgnt_next   = r_pick_idx;
            end
            ARB_BUSY: if (s_rvalid && s_rready && s_rlast) begin
                rstate_next       = ARB_IDLE;
                r_last_grant_next = rgnt_reg;
            end
            default: rstate_next = ARB_IDLE;
        endcase
        case (wstate_reg)
            ARB_IDLE: if (|w_pick_oh) begin
                wstate_next = ARB_BUSY;
                wgnt_next   = w_pick_idx;
            end
            ARB_BUSY: if (s_bvalid && s_bready) begin
                wstate_next       = ARB_IDLE;
                w_last_grant_next = wgnt_reg;
            end
            default: wstate_next = ARB_IDLE;
        endcase
    end

    // Gating the selects with reset silences every channel while reset is high.
    generate
        for (genvar gi = 0; gi < N_MST; gi++) begin : g_mst
            assign rsel[gi] = !reset && (rstate_reg == ARB_BUSY) && (rgnt_reg == IDX_W'(gi));
            assign wsel[gi] = !reset && (wstate_reg == ARB_BUSY) && (wgnt_reg == IDX_W'(gi));

            assign m_arready[gi]      = rsel[gi] & s_arready;
            assign m_rvalid[gi]       = rsel[gi] & s_rvalid;
            assign m_rlast[gi]        = rsel[gi] & s_rlast;
            assign m_rresp[gi*2 +: 2] = rsel[gi] ? s_rresp : 2'b00;
            assign m_rdata[gi*DATA_W +: DATA_W] = (rsel[gi] && s_rvalid) ? s_rdata : hold_reg[gi];

            assign m_awready[gi]      = wsel[gi] & s_awready;
            assign m_wready[gi]       = wsel[gi] & s_wready;
            assign m_bvalid[gi]       = wsel[gi] & s_bvalid;
            assign m_bresp[gi*2 +: 2] = wsel[gi] ? s_bresp : 2'b00;

            always_ff @(posedge clk) begin
                if (reset) begin
                    hold_reg[gi] <= '0;
                end else if (rsel[gi] && s_rvalid) begin
                    hold_reg[gi] <= s_rdata;
                end
            end
        end
    endgenerate

    always_comb begin
        s_arvalid = 1'b0;
        s_araddr  = '0;
        s_arlen   = '0;
        s_arsize  = '0;
        s_rready  = 1'b0;
        s_awvalid = 1'b0;
        s_awaddr  = '0;
        s_awlen   = '0;
        s_awsize  = '0;
        s_wvalid  = 1'b0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wlast   = 1'b0;
        s_bready  = 1'b0;
        for (int i = 0; i < N_MST; i++) begin
            if (rsel[i]) begin
                s_arvalid = m_arvalid[i];
                s_araddr  = m_araddr[i*ADDR_W +: ADDR_W];
                s_arlen   = m_arlen[i*8 +: 8];
                s_arsize  = m_arsize[i*3 +: 3];
                s_rready  = m_rready[i];
            end
            if (wsel[i]) begin
                s_awvalid = m_awvalid[i];
                s_awaddr  = m_awaddr[i*ADDR_W +: ADDR_W];
                s_awlen   = m_awlen[i*8 +: 8];
                s_awsize  = m_awsize[i*3 +: 3];
                s_wvalid  = m_wvalid[i];
                s_wdata   = m_wdata[i*DATA_W +: DATA_W];
                s_wstrb   = m_wstrb[i*STRB_W +: STRB_W];
                s_wlast   = m_wlast[i];
                s_bready  = m_bready[i];
            end
        end
    end

endmodule

// File: doc/ysyx_24100006_axi_nxbar_arbiter.md
YSYX_24100006_AXI_NXBAR_ARBITER -- requirements
Module: ysyx_24100006_axi_nxbar_arbiter

Interface
REQ-001 SHALL have parameter N_MST, default 2: number of AXI masters, legal range 1..8.
REQ-002 SHALL have parameter ADDR_W, default 32: address width.
REQ-003 SHALL have parameter DATA_W, default 32: data width; strobe width is DATA_W/8.
REQ-004 SHALL have parameter ARB_MODE, default 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-005 SHALL have ports, in this order:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- m_ar{valid,ready,addr,len,size}  in/out/in/in/in  N_MST × {1,1,ADDR_W,8,3}  per-master AR channel
- m_r{valid,ready,data,resp,last}  out/in/out/out/out  N_MST × {1,1,DATA_W,2,1}  per-master R channel
- m_aw{valid,ready,addr,len,size}  in/out/in/in/in  N_MST × {1,1,ADDR_W,8,3}  per-master AW channel
- m_w{valid,ready,data,strb,last}  in/out/in/in/in  N_MST × {1,1,DATA_W,DATA_W/8,1}  per-master W channel
- m_b{valid,ready,resp}  out/in/out  N_MST × {1,1,2}  per-master B channel
- s_* mirror of one master set, opposite directions  slave side
All per-master buses are flattened; master i occupies slice i.

Function
REQ-006 SHALL run independent read and write arbiters, each a two-state FSM: IDLE and BUSY.
REQ-007 In IDLE, any m_arvalid high SHALL select a winner; the FSM moves to BUSY and registers rgnt on the next clock edge.
REQ-008 Write arbitration SHALL follow the same rules, using m_awvalid and wgnt.
REQ-009 Round-robin search SHALL start at index (last_grant+1) mod N_MST; fixed mode SHALL choose the lowest asserted index.
REQ-010 In read BUSY, the AR request and R response signals SHALL be forwarded combinationally between master rgnt and the slave, with zero added latency.
REQ-011 In write BUSY, the AW, W and B signals SHALL be forwarded combinationally between master wgnt and the slave.
REQ-012 Every non-granted master SHALL see arready, rvalid, rlast, awready, wready and bvalid at 0, and resp at 0.
REQ-013 In IDLE, the slave SHALL see arvalid, rready, awvalid, wvalid and bready at 0; address and len fields are don't-care and SHALL be driven to 0.
REQ-014 Read BUSY SHALL return to IDLE on s_rvalid & s_rready & s_rlast.
REQ-015 Write BUSY SHALL return to IDLE on s_bvalid & s_bready.
REQ-016 last_grant SHALL be updated when BUSY is left; re-arbitration SHALL not happen before the cycle after release, so there is one idle bubble between grants.
REQ-017 Each master SHALL have a DATA_W hold register, loaded when it is granted and s_rvalid is high.
REQ-018 m_rdata[i] SHALL equal s_rdata while master i is granted with s_rvalid high, and the hold register value otherwise.
REQ-019 wdata and wstrb SHALL pass through unmodified; lane alignment is the master's responsibility.
REQ-020 Read and write grants SHALL be independent; the same master may hold both at once.
REQ-021 With N_MST=1, arbitration SHALL degenerate to immediate grant of master 0, with the same latency.
REQ-022 A master that drops arvalid or awvalid after the winner is selected SHALL keep its grant until completion; no timeout.

Reset
REQ-023 Reset SHALL force both FSMs to IDLE, clear rgnt and wgnt, and set last_grant to N_MST-1 so that master 0 wins first.
REQ-024 Reset SHALL clear all hold registers to 0.
REQ-025 Reset asserted mid-burst SHALL abandon the transaction immediately; all master-side ready, valid and last outputs SHALL read 0 during and after reset until a new grant.

Structure
REQ-026 The state encoding (IDLE/BUSY) and the ARB_MODE constants SHALL live in shared package ysyx_24100006_axi_pkg.
REQ-027 Grant selection SHALL be a sub-module, ysyx_24100006_rr_picker (request vector, last_grant, mode -> one-hot grant and index), instantiated once for read and once for write.

Verification
REQ-028 Simultaneous request: N_MST=3 and RR mode after reset, m_arvalid=3'b111 -> grants in order 0,1,2,0, each held for one burst with a one-cycle bubble between bursts.
REQ-029 Burst read: master 1 reads with arlen=3 while the slave returns 4 beats -> m_rvalid[1] is high 4 times, m_rlast[1] only on beat 4, and IDLE is reached the cycle after beat 4.
REQ-030 Data hold: master 0 reads 0xDEADBEEF, then master 1 reads 0x12345678 -> m_rdata[0] stays 0xDEADBEEF throughout.
REQ-031 Concurrent read/write: master 0 writes 0xA5A5A5A5 with strb=4'b1111 while master 1 reads -> both complete, and the slave sees the unchanged wdata.
REQ-032 Fixed priority: ARB_MODE=1, master 2 requesting continuously, master 0 requesting every 3 cycles -> master 0 always wins when it requests.
REQ-033 Reset mid-burst: reset asserted on beat 2 of 4 -> next cycle both FSMs are IDLE and all m_rvalid=0; a new request is granted to master 0.
